// File: rtl/pipe_stage_skid.sv
// Decode-to-execute pipeline stage: registered main entry backed by a skid entry,
// valid/ready on both sides, synchronous flush that leaves a nop bubble.
module pipe_stage_skid #(
    parameter int unsigned W             = 32,
    parameter int unsigned PC_INC        = 4,
    parameter int unsigned FLUSH_KEEP_PC = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_instr,
    input  logic [W-1:0] in_rs,
    input  logic [W-1:0] in_rt,
    input  logic [W-1:0] in_pc,
    input  logic [W-1:0] in_ext,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_instr,
    output logic [W-1:0] out_rs,
    output logic [W-1:0] out_rt,
    output logic [W-1:0] out_pc,
    output logic [W-1:0] out_ext,
    output logic [1:0]   occupancy
);

    typedef struct packed {
        logic [W-1:0] instr;
        logic [W-1:0] rs;
        logic [W-1:0] rt;
        logic [W-1:0] pc;
        logic [W-1:0] ext;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state_q, state_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    entry_t in_entry;
    logic   accept;
    logic   emit;

    // pc is advanced once at capture and never recomputed on the skid-to-main move
    always_comb begin
        in_entry.instr = in_instr;
        in_entry.rs    = in_rs;
        in_entry.rt    = in_rt;
        in_entry.pc    = in_pc + W'(PC_INC);
        in_entry.ext   = in_ext;
    end

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign occupancy = state_q;
    assign accept    = in_valid & in_ready;
    assign emit      = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
            if (FLUSH_KEEP_PC != 0) begin
                main_d.pc = main_q.pc;
            end
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = ONE;
                        main_d  = in_entry;
                    end
                end
                ONE: begin
                    if (accept && emit) begin
                        main_d = in_entry;
                    end else if (accept) begin
                        state_d = FULL;
                        skid_d  = in_entry;
                    end else if (emit) begin
                        state_d = EMPTY;
                        main_d  = '0;
                    end
                end
                FULL: begin
                    if (emit) begin
                        state_d = ONE;
                        main_d  = skid_q;
                        skid_d  = '0;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign out_instr = main_q.instr;
    assign out_rs    = main_q.rs;
    assign out_rt    = main_q.rt;
    assign out_pc    = main_q.pc;
    assign out_ext   = main_q.ext;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: a FIFO scoreboard predicts every output entry
// for a keep-pc and a clear-pc instance sharing stimulus, plus a 16-bit wrap instance.
module tb_pipe_stage_skid;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] pc;
        logic [31:0] ext;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] in_instr, in_rs, in_rt, in_pc, in_ext;

    logic        rdy_k, val_k, rdy_c, val_c;
    logic [31:0] instr_k, rs_k, rt_k, pc_k, ext_k;
    logic [31:0] instr_c, rs_c, rt_c, pc_c, ext_c;
    logic [1:0]  occ_k, occ_c;

    logic        v16, rdy16, val16;
    logic [15:0] instr16, pc16;
    logic [15:0] oinstr16, ors16, ort16, opc16, oext16;
    logic [1:0]  occ16;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    ent_t        q[$];
    logic [31:0] held_k = '0;
    logic        acc_last;

    always #5 clk = ~clk;

    pipe_stage_skid #(.W(32), .PC_INC(4), .FLUSH_KEEP_PC(1)) dut_k (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy_k),
        .in_instr(in_instr), .in_rs(in_rs), .in_rt(in_rt), .in_pc(in_pc), .in_ext(in_ext),
        .out_valid(val_k), .out_ready(out_ready),
        .out_instr(instr_k), .out_rs(rs_k), .out_rt(rt_k), .out_pc(pc_k), .out_ext(ext_k),
        .occupancy(occ_k)
    );

    pipe_stage_skid #(.W(32), .PC_INC(4), .FLUSH_KEEP_PC(0)) dut_c (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy_c),
        .in_instr(in_instr), .in_rs(in_rs), .in_rt(in_rt), .in_pc(in_pc), .in_ext(in_ext),
        .out_valid(val_c), .out_ready(out_ready),
        .out_instr(instr_c), .out_rs(rs_c), .out_rt(rt_c), .out_pc(pc_c), .out_ext(ext_c),
        .occupancy(occ_c)
    );

    pipe_stage_skid #(.W(16), .PC_INC(2), .FLUSH_KEEP_PC(0)) dut_16 (
        .clk(clk), .reset(reset), .flush(1'b0),
        .in_valid(v16), .in_ready(rdy16),
        .in_instr(instr16), .in_rs(16'h0011), .in_rt(16'h0022), .in_pc(pc16), .in_ext(16'h0033),
        .out_valid(val16), .out_ready(1'b1),
        .out_instr(oinstr16), .out_rs(ors16), .out_rt(ort16), .out_pc(opc16), .out_ext(oext16),
        .occupancy(occ16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        in_valid = v;
        in_instr = instr;
        in_rs    = instr ^ 32'h0000_FFFF;
        in_rt    = instr + 32'd7;
        in_pc    = pc;
        in_ext   = ~instr;
    endtask

    task automatic check_outputs();
        logic [2:0] n;
        n = 3'(q.size());
        chk("val_k", {31'd0, val_k}, {31'd0, n != 0});
        chk("val_c", {31'd0, val_c}, {31'd0, n != 0});
        chk("occ_k", {30'd0, occ_k}, {29'd0, n});
        chk("occ_c", {30'd0, occ_c}, {29'd0, n});
        chk("rdy_k", {31'd0, rdy_k}, {31'd0, n != 2});
        chk("rdy_c", {31'd0, rdy_c}, {31'd0, n != 2});
        if (n != 0) begin
            chk("instr_k", instr_k, q[0].instr);
            chk("rs_k",    rs_k,    q[0].rs);
            chk("rt_k",    rt_k,    q[0].rt);
            chk("pc_k",    pc_k,    q[0].pc);
            chk("ext_k",   ext_k,   q[0].ext);
            chk("instr_c", instr_c, q[0].instr);
            chk("pc_c",    pc_c,    q[0].pc);
        end else begin
            chk("instr_k_empty", instr_k, 32'd0);
            chk("rs_k_empty",    rs_k,    32'd0);
            chk("ext_k_empty",   ext_k,   32'd0);
            chk("pc_k_empty",    pc_k,    held_k);
            chk("instr_c_empty", instr_c, 32'd0);
            chk("pc_c_empty",    pc_c,    32'd0);
        end
    endtask

    // Check at the falling edge, then advance the reference FIFO at the rising edge.
    task automatic cycle();
        logic acc, em;
        ent_t e;
        @(negedge clk);
        check_outputs();
        acc = in_valid && (q.size() < 2);
        em  = (q.size() > 0) && out_ready;
        e.instr = in_instr;
        e.rs    = in_rs;
        e.rt    = in_rt;
        e.pc    = in_pc + 32'd4;
        e.ext   = in_ext;
        @(posedge clk);
        if (flush) begin
            if (q.size() > 0) held_k = q[0].pc;
            q.delete();
        end else begin
            if (em) begin
                void'(q.pop_front());
                if (q.size() == 0 && !acc) held_k = '0;
            end
            if (acc) q.push_back(e);
        end
        acc_last = acc && !flush;
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_val_k"},   {31'd0, val_k}, 32'd0);
        chk({tag, "_occ_k"},   {30'd0, occ_k}, 32'd0);
        chk({tag, "_rdy_k"},   {31'd0, rdy_k}, 32'd1);
        chk({tag, "_instr_k"}, instr_k, 32'd0);
        chk({tag, "_pc_k"},    pc_k,    32'd0);
        chk({tag, "_ext_k"},   ext_k,   32'd0);
        chk({tag, "_val_c"},   {31'd0, val_c}, 32'd0);
        chk({tag, "_rdy_c"},   {31'd0, rdy_c}, 32'd1);
        chk({tag, "_val16"},   {31'd0, val16}, 32'd0);
        chk({tag, "_pc16"},    {16'd0, opc16}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        v16 = 1'b0; instr16 = '0; pc16 = '0;
        drive(1'b0, 32'd0, 32'd0);
        #2;
        check_reset_state("por");
        #10 reset = 1'b0;
        @(posedge clk); #1;

        // single transfer then idle
        out_ready = 1'b1;
        drive(1'b1, 32'h8C01_0004, 32'h0000_3000);
        cycle();
        drive(1'b0, 32'd0, 32'd0);
        cycle();
        cycle();

        // backpressure: A, B fill the stage, C waits upstream
        out_ready = 1'b0;
        drive(1'b1, 32'hA000_0001, 32'h0000_3100); cycle();
        drive(1'b1, 32'hB000_0002, 32'h0000_3104); cycle();
        drive(1'b1, 32'hC000_0003, 32'h0000_3108); cycle();
        cycle();
        out_ready = 1'b1;
        repeat (5) begin
            cycle();
            if (acc_last) in_valid = 1'b0;
        end

        // flush while full
        out_ready = 1'b0;
        drive(1'b1, 32'h1111_0001, 32'h0000_300C); cycle();
        drive(1'b1, 32'h2222_0002, 32'h0000_3020); cycle();
        in_valid = 1'b0; cycle();
        flush = 1'b1; cycle();
        flush = 1'b0; cycle();
        cycle();

        // flush together with accept and emit
        drive(1'b1, 32'h3333_0003, 32'h0000_4000); cycle();
        drive(1'b1, 32'h4444_0004, 32'h0000_5000);
        out_ready = 1'b1; flush = 1'b1; cycle();
        flush = 1'b0; in_valid = 1'b0; cycle();
        cycle();

        // pc wrap on both widths
        drive(1'b1, 32'h5555_0005, 32'hFFFF_FFFC);
        v16 = 1'b1; pc16 = 16'hFFFF; instr16 = 16'h1234;
        cycle();
        chk("val16",   {31'd0, val16},   32'd1);
        chk("pc16",    {16'd0, opc16},   32'h0000_0001);
        chk("instr16", {16'd0, oinstr16}, 32'h0000_1234);
        chk("ext16",   {16'd0, oext16},  32'h0000_0033);
        v16 = 1'b0;
        in_valid = 1'b0; cycle();
        cycle();

        // async reset while full, released so the next edge can accept
        out_ready = 1'b0;
        drive(1'b1, 32'h6666_0006, 32'h0000_6000); cycle();
        drive(1'b1, 32'h7777_0007, 32'h0000_6004); cycle();
        in_valid = 1'b0;
        #1 reset = 1'b1;
        #1;
        check_reset_state("async");
        q.delete();
        held_k = '0;
        reset = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 32'h8888_0008, 32'h0000_7000);
        cycle();
        in_valid = 1'b0; cycle();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
